ga23_sdr_arbiter: RTL and testbench

// - Shares the single SDRAM tile-ROM read port between the GA23 tile layers.
// - Each layer issues a one-cycle sdr_req pulse with a row address, then waits for its sdr_rdy.
// - This block queues one pending request per layer and grants the port round-robin.
// - It routes the returned 32-bit row back to the requesting layer.
// - Sits between the ga23_layer instances and the SDRAM controller's tile channel.

---
 rtl/ga23_pkg.sv | 6 +
 rtl/ga23_rr_pick.sv | 24 ++
 rtl/ga23_sdr_arbiter.sv | 92 +++++++++
 tb/tb_ga23_sdr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga23_pkg.sv
// ga23_pkg: shared types and widths for the GA23 tile-ROM SDRAM arbiter.
package ga23_pkg;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;
    localparam int GA23_SDR_ADDR_W = 22;
    localparam int GA23_SDR_DATA_W = 32;
endpackage

// File: rtl/ga23_rr_pick.sv
// ga23_rr_pick: combinational round-robin picker, first pending bit after i_last_grant (wrapping).
module ga23_rr_pick #(
    parameter int N  = 3,
    parameter int LW = 2
) (
    input  logic [N-1:0]  i_pending,
    input  logic [LW-1:0] i_last_grant,
    output logic [LW-1:0] o_grant,
    output logic          o_valid
);
    always_comb begin
        int best;
        best    = N;
        o_grant = '0;
        o_valid = |i_pending;
        // distance 0 is the layer right after the last grant
        for (int j = 0; j < N; j++) begin
            if (i_pending[j] && ((j + N - 1 - int'(i_last_grant)) % N) < best) begin
                best    = (j + N - 1 - int'(i_last_grant)) % N;
                o_grant = LW'(j);
            end
        end
    end
endmodule

// File: rtl/ga23_sdr_arbiter.sv
// ga23_sdr_arbiter: shares the SDRAM tile-ROM read port between GA23 tile layers,
// one pending request per layer, round-robin grant, one transaction outstanding.
module ga23_sdr_arbiter
    import ga23_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int ADDR_W     = GA23_SDR_ADDR_W,
    parameter int DATA_W     = GA23_SDR_DATA_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_LAYERS-1:0]        req,
    input  logic [NUM_LAYERS*ADDR_W-1:0] req_addr,
    output logic [NUM_LAYERS-1:0]        rdy,
    output logic [NUM_LAYERS*DATA_W-1:0] rdy_data,
    output logic                         mem_req,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_rdy,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         busy
);
    localparam int LW = NUM_LAYERS > 1 ? $clog2(NUM_LAYERS) : 1;

    arb_state_t                   r_state, w_next;
    logic [NUM_LAYERS-1:0]        r_pending, r_stale, r_rdy, w_clr;
    logic [ADDR_W-1:0]            r_addr_q [NUM_LAYERS];
    logic [ADDR_W-1:0]            r_mem_addr;
    logic [NUM_LAYERS*DATA_W-1:0] r_rdy_data;
    logic [LW-1:0]                r_grant, w_pick;
    logic                         w_valid, w_take, w_done, w_drop;

    ga23_rr_pick #(.N(NUM_LAYERS), .LW(LW)) u_pick (
        .i_pending    (r_pending),
        .i_last_grant (r_grant),
        .o_grant      (w_pick),
        .o_valid      (w_valid)
    );

    assign w_take   = r_state == ARB_IDLE && w_valid;
    assign w_done   = r_state == ARB_WAIT && mem_rdy;
    // a re-request landing on the completion edge also supersedes this data
    assign w_drop   = r_stale[r_grant] | req[r_grant];
    assign w_clr    = w_take ? NUM_LAYERS'(1) << w_pick : '0;
    assign rdy      = r_rdy;
    assign rdy_data = r_rdy_data;
    assign mem_addr = r_mem_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ARB_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        mem_req = r_state == ARB_ISSUE;
        busy    = r_state != ARB_IDLE;
        w_next  = r_state == ARB_IDLE  ? (w_valid ? ARB_ISSUE : ARB_IDLE) :
                  r_state == ARB_ISSUE ? ARB_WAIT :
                  mem_rdy              ? ARB_IDLE : ARB_WAIT;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_stale    <= '0;
            r_rdy      <= '0;
            r_rdy_data <= '0;
            r_mem_addr <= '0;
            r_grant    <= LW'(NUM_LAYERS - 1);
            for (int i = 0; i < NUM_LAYERS; i++) r_addr_q[i] <= '0;
        end else begin
            r_rdy     <= '0;
            r_pending <= (r_pending & ~w_clr) | req;
            for (int i = 0; i < NUM_LAYERS; i++)
                if (req[i]) r_addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
            if (w_take) begin
                r_grant    <= w_pick;
                r_mem_addr <= r_addr_q[w_pick];
                if (req[w_pick]) r_stale[w_pick] <= 1'b1;
            end
            if (w_done) begin
                r_stale[r_grant] <= 1'b0;
                if (!w_drop) begin
                    r_rdy[r_grant]                       <= 1'b1;
                    r_rdy_data[r_grant*DATA_W +: DATA_W] <= mem_data;
                end
            end else if (r_state != ARB_IDLE && req[r_grant]) begin
                r_stale[r_grant] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// tb_ga23_sdr_arbiter: random and directed stimulus against a round-robin / latest-wins
// reference model; a negedge monitor scores every grant and every rdy.
module tb_ga23_sdr_arbiter;
    localparam int N  = 3;
    localparam int AW = 22;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    rdy;
    logic [N*DW-1:0] rdy_data;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_rdy = 1'b0;
    logic [DW-1:0]   mem_data = '0;
    logic            busy;

    ga23_sdr_arbiter #(.NUM_LAYERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_addr (req_addr),
        .rdy      (rdy),
        .rdy_data (rdy_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_rdy  (mem_rdy),
        .mem_data (mem_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state
    bit            waiting [N];
    int            req_edge [N];
    bit            exp_v [N];
    logic [AW-1:0] exp_a [N];
    logic [DW-1:0] model_rd [N];
    int            grant_no [N];
    int            last_g = N - 1;
    int            n_grants = 0;
    int            n_memreq = 0;
    logic [AW-1:0] hold_a = '0;
    bit            resp_en = 1'b0;
    int            fix_delay = -1;

    function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
        return a == 22'h012340 ? 32'hDEADBEEF : {a[9:0], a} ^ 32'h5A5A3C3C;
    endfunction

    function automatic logic [N*DW-1:0] model_pack();
        logic [N*DW-1:0] p;
        for (int i = 0; i < N; i++) p[i*DW +: DW] = model_rd[i];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            waiting[i]  = 1'b0;
            exp_v[i]    = 1'b0;
            model_rd[i] = '0;
        end
        last_g = N - 1;
    endtask

    // called at posedge+1; holds req for one cycle
    task automatic pulse(input logic [N-1:0] m, input logic [AW-1:0] a0, a1, a2);
        logic [AW-1:0] a [N];
        a[0] = a0; a[1] = a1; a[2] = a2;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                req_addr[i*AW +: AW] = a[i];
                waiting[i]  = 1'b1;
                req_edge[i] = cyc + 1;
                exp_v[i]    = 1'b1;
                exp_a[i]    = a[i];
            end
        end
        req = m;
        @(posedge clk); #1;
        req = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_clear();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic wait_mem_req(input string nm);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = mem_req;
        end
        chk(nm, 128'(seen), 128'd1);
    endtask

    task automatic wait_layer(input int i);
        for (int t = 0; t < 100 && exp_v[i]; t++) @(negedge clk);
        chk("layer_rdy_timeout", 128'(exp_v[i]), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit any;
        any = 1'b1;
        for (int t = 0; t < 400 && any; t++) begin
            @(negedge clk);
            any = 1'b0;
            for (int i = 0; i < N; i++) any |= exp_v[i];
        end
        chk("drain_timeout", 128'(any), 128'd0);
        @(posedge clk); #1;
    endtask

    // memory responder
    initial begin
        logic [AW-1:0] a;
        int d;
        forever begin
            @(negedge clk);
            if (mem_req && resp_en && reset_n) begin
                a = mem_addr;
                d = fix_delay < 0 ? int'($urandom_range(0, 4)) : fix_delay;
                repeat (d) @(posedge clk);
                @(posedge clk); #1;
                mem_rdy  = 1'b1;
                mem_data = rom(a);
                @(posedge clk); #1;
                mem_rdy  = 1'b0;
                mem_data = '0;
            end
        end
    end

    // monitor: round-robin grant order, address hold, rdy routing and data
    always @(negedge clk) begin
        int g;
        g = -1;
        if (reset_n) begin
            if (mem_req) begin
                n_memreq++;
                for (int k = 1; k <= N; k++) begin
                    int j;
                    j = (last_g + k) % N;
                    if (g < 0 && waiting[j] && req_edge[j] < cyc) g = j;
                end
                tests++;
                if (g < 0) begin
                    fails++;
                    $display("FAIL grant_spurious: mem_req=1 addr %0h, expected no grant", mem_addr);
                end else begin
                    chk("grant_addr", 128'(mem_addr), 128'(exp_a[g]));
                    waiting[g]  = 1'b0;
                    last_g      = g;
                    grant_no[g] = n_grants;
                    n_grants++;
                end
                hold_a = mem_addr;
            end else if (busy) begin
                chk("mem_addr_hold", 128'(mem_addr), 128'(hold_a));
            end
            chk("rdy_onehot", 128'($countones(rdy) <= 1), 128'd1);
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    tests++;
                    if (!exp_v[i]) begin
                        fails++;
                        $display("FAIL rdy_unexpected: rdy[%0d]=1, expected 0", i);
                    end else begin
                        chk("rdy_data", 128'(rdy_data[i*DW +: DW]), 128'(rom(exp_a[i])));
                        model_rd[i] = rom(exp_a[i]);
                        exp_v[i]    = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        int n0, g2_base;
        logic [N-1:0] m;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rdy", 128'(rdy), 128'd0);
        chk("reset_rdy_data", 128'(rdy_data), 128'd0);
        chk("reset_mem_req", 128'(mem_req), 128'd0);
        chk("reset_mem_addr", 128'(mem_addr), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single request, manual 5-cycle memory latency
        n0 = n_memreq;
        pulse(3'b001, 22'h012340, '0, '0);
        @(negedge clk);
        chk("lat_pending", 128'(mem_req), 128'd0);
        @(negedge clk);
        chk("lat_issue", 128'(mem_req), 128'd1);
        chk("single_addr", 128'(mem_addr), 128'h012340);
        chk("single_busy", 128'(busy), 128'd1);
        repeat (5) @(posedge clk);
        #1;
        mem_rdy = 1'b1; mem_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_rdy = 1'b0; mem_data = '0;
        @(negedge clk);
        chk("single_rdy", 128'(rdy), 128'b001);
        chk("single_data", 128'(rdy_data[DW-1:0]), 128'hDEADBEEF);
        @(negedge clk);
        chk("single_rdy_pulse", 128'(rdy), 128'd0);
        chk("single_memreq_count", 128'(n_memreq - n0), 128'd1);
        @(posedge clk); #1;

        // simultaneous requests from reset, then wrap after last_grant=2
        do_reset();
        resp_en = 1'b1; fix_delay = 1;
        pulse(3'b111, 22'd1, 22'd2, 22'd3);
        wait_done();
        chk("order_0", 128'(grant_no[0] < grant_no[1]), 128'd1);
        chk("order_1", 128'(grant_no[1] < grant_no[2]), 128'd1);
        pulse(3'b011, 22'd4, 22'd5, '0);
        wait_done();
        chk("wrap_order", 128'(grant_no[0] < grant_no[1]), 128'd1);

        // fairness: layer 0 hogs, layer 2 asks once
        fix_delay = -1;
        pulse(3'b001, 22'h100, '0, '0);
        @(posedge clk); #1;
        g2_base = n_grants;
        pulse(3'b100, '0, '0, 22'h300);
        for (int t = 0; t < 6; t++) begin
            wait_layer(0);
            pulse(3'b001, 22'(22'h101 + t), '0, '0);
        end
        wait_done();
        chk("fair_layer2", 128'(grant_no[2] - g2_base <= 1), 128'd1);

        // stale: re-request during WAIT supersedes the in-flight address
        resp_en = 1'b0;
        pulse(3'b010, '0, 22'd10, '0);
        wait_mem_req("stale_first_issue");
        @(posedge clk); #1;
        pulse(3'b010, '0, 22'd20, '0);
        mem_rdy = 1'b1; mem_data = rom(22'd10);
        @(posedge clk); #1;
        mem_rdy = 1'b0; mem_data = '0;
        resp_en = 1'b1;
        @(negedge clk);
        chk("stale_no_rdy", 128'(rdy), 128'd0);
        wait_done();
        chk("stale_data", 128'(rdy_data[DW +: DW]), 128'(rom(22'd20)));

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            m = '0;
            for (int i = 0; i < N; i++)
                if (!exp_v[i] && $urandom_range(0, 2) == 0) m[i] = 1'b1;
            pulse(m, 22'($urandom), 22'($urandom), 22'($urandom));
        end
        wait_done();
        chk("random_rdy_data", 128'(rdy_data), 128'(model_pack()));

        // spurious mem_rdy in IDLE
        mem_rdy = 1'b1; mem_data = 32'hBADBAD00;
        @(posedge clk); #1;
        mem_rdy = 1'b0; mem_data = '0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            chk("spur_busy", 128'(busy), 128'd0);
            chk("spur_rdy", 128'(rdy), 128'd0);
        end
        chk("spur_rdy_data", 128'(rdy_data), 128'(model_pack()));
        @(posedge clk); #1;

        // reset in WAIT with layer 2 pending, then a late mem_rdy
        resp_en = 1'b0;
        pulse(3'b001, 22'h2A0, '0, '0);
        wait_mem_req("rst_issue");
        @(posedge clk); #1;
        pulse(3'b100, '0, '0, 22'h2A2);
        do_reset();
        mem_rdy = 1'b1; mem_data = 32'h12345678;
        @(posedge clk); #1;
        mem_rdy = 1'b0; mem_data = '0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("rst_busy", 128'(busy), 128'd0);
            chk("rst_mem_req", 128'(mem_req), 128'd0);
            chk("rst_rdy", 128'(rdy), 128'd0);
        end
        chk("rst_rdy_data", 128'(rdy_data), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
